// File: rtl/dmem_arbiter.sv
// Arbiter for the single-ported data memory: core load/store vs DMA bursts.
// Core wins contention in a way that bounds DMA runs while the core is stalled.
module dmem_arbiter #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned ADDR_STEP   = 8,
  parameter int unsigned MAX_DMA_RUN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ready,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned RUN_W = $clog2(MAX_DMA_RUN + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_nxt;
  logic               last_gnt, last_gnt_nxt;   // 0 = core, 1 = DMA
  logic [LEN_W-1:0]   beat, beat_nxt;
  logic [LEN_W-1:0]   len, len_nxt;
  logic [ADDR_W-1:0]  base, base_nxt;
  logic               dir, dir_nxt;
  logic [RUN_W-1:0]   run, run_nxt;

  logic               gnt_core, gnt_dma, done;
  logic [ADDR_W-1:0]  beat_addr, dma_cur_addr;
  logic               dma_cur_we;

  assign beat_addr    = base + ADDR_W'(beat) * ADDR_W'(ADDR_STEP);
  assign dma_cur_addr = (state == IDLE) ? dma_addr : beat_addr;
  assign dma_cur_we   = (state == IDLE) ? dma_we : dir;

  // Grant decision and next-state; nothing is granted while reset is held low.
  always_comb begin
    gnt_core     = 1'b0;
    gnt_dma      = 1'b0;
    done         = 1'b0;
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    beat_nxt     = beat;
    len_nxt      = len;
    base_nxt     = base;
    dir_nxt      = dir;
    run_nxt      = run;
    if (reset) begin
      case (state)
        IDLE: begin
          if (core_req && (!dma_req || last_gnt)) begin
            gnt_core     = 1'b1;
            last_gnt_nxt = 1'b0;
            run_nxt      = '0;
          end else if (dma_req) begin
            gnt_dma      = 1'b1;
            last_gnt_nxt = 1'b1;
            base_nxt     = dma_addr;
            len_nxt      = dma_len;
            dir_nxt      = dma_we;
            beat_nxt     = LEN_W'(1);
            run_nxt      = core_req ? RUN_W'(1) : '0;
            if (dma_len == '0) begin
              done     = 1'b1;
              beat_nxt = '0;
              run_nxt  = '0;
            end else begin
              state_nxt = BURST;
            end
          end
        end
        BURST: begin
          if (core_req && (run == RUN_W'(MAX_DMA_RUN))) begin
            gnt_core = 1'b1;
            run_nxt  = '0;
          end else if (dma_req) begin
            gnt_dma  = 1'b1;
            beat_nxt = beat + LEN_W'(1);
            run_nxt  = core_req ? run + RUN_W'(1) : '0;
            if (beat == len) begin
              done         = 1'b1;
              state_nxt    = IDLE;
              last_gnt_nxt = 1'b1;
              run_nxt      = '0;
              beat_nxt     = '0;
            end
          end else begin
            // Paused burst: the core may use the memory in the gap.
            gnt_core = core_req;
            run_nxt  = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      beat     <= '0;
      len      <= '0;
      base     <= '0;
      dir      <= 1'b0;
      run      <= '0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      beat     <= beat_nxt;
      len      <= len_nxt;
      base     <= base_nxt;
      dir      <= dir_nxt;
      run      <= run_nxt;
    end
  end

  assign mem_we     = (gnt_core & core_we) | (gnt_dma & dma_cur_we);
  assign mem_re     = (gnt_core & ~core_we) | (gnt_dma & ~dma_cur_we);
  assign mem_addr   = gnt_core ? core_addr  : (gnt_dma ? dma_cur_addr : '0);
  assign mem_wdata  = gnt_core ? core_wdata : (gnt_dma ? dma_wdata : '0);
  assign core_rdata = gnt_core ? mem_rdata : '0;
  assign core_stall = core_req & ~gnt_core;
  assign dma_ready  = gnt_dma;
  assign dma_rdata  = gnt_dma ? mem_rdata : '0;
  assign dma_done   = done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        core_req, core_we;
  logic [63:0] core_addr, core_wdata, core_rdata;
  logic        core_stall;
  logic        dma_req, dma_we;
  logic [63:0] dma_addr, dma_wdata, dma_rdata;
  logic [3:0]  dma_len;
  logic        dma_ready, dma_done;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  int errors = 0;
  int checks = 0;

  logic [63:0] mem [256];

  dmem_arbiter dut (
    .clk(clk), .reset(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_ready(dma_ready), .dma_rdata(dma_rdata),
    .dma_done(dma_done), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational read, write at the clock edge.
  assign mem_rdata = mem[mem_addr[10:3]];
  always @(posedge clk) if (mem_we) mem[mem_addr[10:3]] <= mem_wdata;

  typedef struct {
    string       name;
    logic        rst;
    logic        creq, cwe;
    logic [63:0] caddr, cwdata;
    logic        dreq, dwe;
    logic [63:0] daddr;
    logic [3:0]  dlen;
    logic [63:0] dwdata;
    logic        e_stall, e_ready, e_done, e_we, e_re;
    logic [63:0] e_addr;
    logic        rd_chk;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string nm, input logic rst,
                     input logic creq, input logic cwe, input logic [63:0] caddr, input logic [63:0] cwdata,
                     input logic dreq, input logic dwe, input logic [63:0] daddr, input logic [3:0] dlen,
                     input logic [63:0] dwdata,
                     input logic es, input logic er, input logic ed, input logic ewe, input logic ere,
                     input logic [63:0] ea, input logic rc, input logic [63:0] erd);
    vec_t v;
    v.name = nm; v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwdata = cwdata;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dlen = dlen; v.dwdata = dwdata;
    v.e_stall = es; v.e_ready = er; v.e_done = ed; v.e_we = ewe; v.e_re = ere;
    v.e_addr = ea; v.rd_chk = rc; v.e_rdata = erd;
    vq.push_back(v);
  endtask

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic set_in(input logic rst, input logic creq, input logic cwe, input logic [63:0] caddr,
                        input logic [63:0] cwdata, input logic dreq, input logic dwe,
                        input logic [63:0] daddr, input logic [3:0] dlen, input logic [63:0] dwdata);
    rst_n = rst; core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwdata;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_len = dlen; dma_wdata = dwdata;
  endtask

  task automatic expect_out(input string nm, input logic es, input logic er, input logic ed,
                            input logic ewe, input logic ere, input logic [63:0] ea);
    chk({nm, ".stall"}, 64'(core_stall), 64'(es));
    chk({nm, ".ready"}, 64'(dma_ready), 64'(er));
    chk({nm, ".done"},  64'(dma_done), 64'(ed));
    chk({nm, ".we"},    64'(mem_we), 64'(ewe));
    chk({nm, ".re"},    64'(mem_re), 64'(ere));
    chk({nm, ".addr"},  mem_addr, ea);
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset holds everything off; core_stall follows core_req.
    add("rst_core", 0, 1,0,64'h40,64'h5, 0,0,0,0,0, 1,0,0,0,0, 0, 1, 0);
    add("rst_dma",  0, 0,0,0,0, 1,1,64'h80,4'd2,64'h9, 0,0,0,0,0, 0, 0, 0);
    // First contention after reset goes to the core.
    add("cont", 1, 1,0,64'h40,0, 1,1,64'h200,4'd15,64'hA00, 0,0,0,0,1, 64'h40, 0, 0);
    // 16-beat burst with core_req held: 8 beats, one core slot, 8 beats.
    for (int k = 0; k < 17; k++) begin
      if (k == 8)
        add($sformatf("run_core%0d", k), 1, 1,0,64'h40,0, 1,1,64'h200,4'd15,64'hBAD,
            0,0,0,0,1, 64'h40, 0, 0);
      else begin
        int b;
        b = (k < 8) ? k : k - 1;
        add($sformatf("burst16_%0d", k), 1, 1,0,64'h40,0, 1,1,64'h200,4'd15,64'hA00 + 64'(b),
            1,1,(b == 15),1,0, 64'h200 + 64'(8 * b), 0, 0);
      end
    end
    add("st40", 1, 1,1,64'h40,64'hDEAD_BEEF, 0,0,0,0,0, 0,0,0,1,0, 64'h40, 0, 0);
    add("ld40", 1, 1,0,64'h40,0, 0,0,0,0,0, 0,0,0,0,1, 64'h40, 1, 64'hDEAD_BEEF);
    for (int k = 0; k < 4; k++)
      add($sformatf("wb_%0d", k), 1, 0,0,0,0, 1,1,64'h100,4'd3,64'h1000 + 64'(k),
          0,1,(k == 3),1,0, 64'h100 + 64'(8 * k), 0, 0);
    add("ld118", 1, 1,0,64'h118,0, 0,0,0,0,0, 0,0,0,0,1, 64'h118, 1, 64'h1003);
    add("ld208", 1, 1,0,64'h208,0, 0,0,0,0,0, 0,0,0,0,1, 64'h208, 1, 64'hA01);
    add("ld240", 1, 1,0,64'h240,0, 0,0,0,0,0, 0,0,0,0,1, 64'h240, 1, 64'hA08);
    add("ld278", 1, 1,0,64'h278,0, 0,0,0,0,0, 0,0,0,0,1, 64'h278, 1, 64'hA0F);
    add("idle",  1, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0, 1, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      set_in(vq[i].rst, vq[i].creq, vq[i].cwe, vq[i].caddr, vq[i].cwdata,
             vq[i].dreq, vq[i].dwe, vq[i].daddr, vq[i].dlen, vq[i].dwdata);
      #2;
      expect_out(vq[i].name, vq[i].e_stall, vq[i].e_ready, vq[i].e_done,
                 vq[i].e_we, vq[i].e_re, vq[i].e_addr);
      if (vq[i].rd_chk) chk({vq[i].name, ".rdata"}, core_rdata, vq[i].e_rdata);
    end

    // Single-beat DMA read: done in the same cycle, stays idle.
    @(negedge clk);
    set_in(1, 0,0,0,0, 1,0,64'h40,4'd0,0);
    #2;
    expect_out("rd1", 0,1,1,0,1, 64'h40);
    chk("rd1.dma_rdata", dma_rdata, 64'hDEAD_BEEF);
    chk("rd1.core_rdata", core_rdata, 64'h0);

    // Wrapping burst with a two-cycle pause before the last beat.
    @(negedge clk);
    set_in(1, 0,0,0,0, 1,1,64'hFFFF_FFFF_FFFF_FFF8,4'd1,64'h77);
    #2;
    expect_out("wrap0", 0,1,0,1,0, 64'hFFFF_FFFF_FFFF_FFF8);
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      set_in(1, 0,0,0,0, 0,1,64'h500,4'd5,64'h99);
      #2;
      expect_out($sformatf("gap%0d", g), 0,0,0,0,0, 64'h0);
    end
    @(negedge clk);
    set_in(1, 0,0,0,0, 1,0,64'h500,4'd5,64'h78);
    #2;
    expect_out("wrap1", 0,1,1,1,0, 64'h0);
    @(negedge clk);
    set_in(1, 1,0,64'hFFFF_FFFF_FFFF_FFF8,0, 0,0,0,0,0);
    #2;
    expect_out("ld_top", 0,0,0,0,1, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("ld_top.rdata", core_rdata, 64'h77);
    @(negedge clk);
    set_in(1, 1,0,64'h0,0, 0,0,0,0,0);
    #2;
    chk("ld_zero.rdata", core_rdata, 64'h78);

    // Reset asserted in the middle of beat 2 of a 4-beat burst.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_in(1, 0,0,0,0, 1,1,64'h300,4'd3,64'h31 + 64'(k));
      #2;
      expect_out($sformatf("pre_rst%0d", k), 0,1,0,1,0, 64'h300 + 64'(8 * k));
    end
    #1;
    rst_n = 1'b0;
    core_req = 1'b1;
    #1;
    expect_out("mid_rst", 1,0,0,0,0, 64'h0);
    chk("mid_rst.wdata", mem_wdata, 64'h0);
    chk("mid_rst.dma_rdata", dma_rdata, 64'h0);
    chk("mid_rst.core_rdata", core_rdata, 64'h0);
    @(negedge clk);
    set_in(0, 0,0,0,0, 1,1,64'h300,4'd3,64'h34);
    #2;
    expect_out("hold_rst", 0,0,0,0,0, 64'h0);
    @(negedge clk);
    set_in(1, 0,0,0,0, 1,1,64'h400,4'd1,64'h41);
    #2;
    expect_out("post0", 0,1,0,1,0, 64'h400);
    @(negedge clk);
    set_in(1, 0,0,0,0, 1,1,64'h400,4'd1,64'h42);
    #2;
    expect_out("post1", 0,1,1,1,0, 64'h408);
    @(negedge clk);
    set_in(1, 0,0,0,0, 0,0,0,0,0);
    #2;
    expect_out("post_idle", 0,0,0,0,0, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
